ram_s2p1c_arbiter: RTL and testbench
====================================

Name: ram_s2p1c_arbiter

Overview:
- Shares one simple dual-port RAM (1 write port A, 1 registered read port B, 1-cycle read latency) between NUM_CLIENTS requesters.
- Arbitrates write and read ports independently, each round-robin, so one write and one read can be granted per cycle.
- Routes each read response back to its issuing client.
- Sits between client logic and the RAM instance; the RAM is external to this block.

Parameters:
- NUM_CLIENTS, 4, number of requesters (2..16)
- WORD_WIDTH, 8, RAM word width
- WORD_COUNT, 256, RAM depth; ADDR_WIDTH = $clog2(WORD_COUNT) (localparam)

Ports:
- clk_i  in  1  clock; all logic on posedge
- rst_i  in  1  synchronous reset, active-high
- wr_valid_i  in  NUM_CLIENTS  per-client write request
- wr_ready_o  out  NUM_CLIENTS  per-client write grant (one-hot or zero)
- wr_addr_i  in  NUM_CLIENTS*ADDR_WIDTH  packed write addresses, client i at slice i
- wr_data_i  in  NUM_CLIENTS*WORD_WIDTH  packed write data
- rd_valid_i  in  NUM_CLIENTS  per-client read request
- rd_ready_o  out  NUM_CLIENTS  per-client read grant (one-hot or zero)
- rd_addr_i  in  NUM_CLIENTS*ADDR_WIDTH  packed read addresses
- rsp_valid_o  out  NUM_CLIENTS  one-hot read-response strobe
- rsp_data_o  out  WORD_WIDTH  read data, common to all clients; qualified by rsp_valid_o
- ram_we_o  out  1  to RAM write enable
- ram_waddr_o  out  ADDR_WIDTH  to RAM write address
- ram_wdata_o  out  WORD_WIDTH  to RAM write data
- ram_raddr_o  out  ADDR_WIDTH  to RAM read address
- ram_rdata_i  in  WORD_WIDTH  from RAM read data (valid 1 cycle after address)

Behaviour:
- Clocking and reset: one clock (clk_i); reset rst_i is synchronous, active-high.
- Handshake: valid/ready per client.
  - Transfer occurs in a cycle where valid & ready are both high.
  - Ready is combinational from valid and the priority pointer.
  - Client holds valid/addr/data stable until ready.
- Write arbiter:
  - Round-robin starting at wr_ptr; grants the first requesting client at or after wr_ptr (modulo NUM_CLIENTS).
  - ram_we_o = |wr_ready_o; ram_waddr_o/ram_wdata_o = granted client's slice; both 0 when no grant.
  - On a grant to client g, wr_ptr <= (g+1) mod NUM_CLIENTS; with no grant, wr_ptr holds.
- Read arbiter:
  - Same scheme with rd_ptr; ram_raddr_o = granted client's address, 0 when idle.
  - Registers rsp_sel <= rd_ready_o (one-hot) each cycle.
- Response path:
  - rsp_valid_o = rsp_sel, i.e. exactly 1 cycle after the read grant; rsp_data_o = ram_rdata_i.
  - Latency is request-accept to response = 1 cycle.
  - Back-to-back reads by the same or different clients are accepted every cycle.
- Fairness: a continuously requesting client is granted within NUM_CLIENTS cycles on each port.
- Simultaneous write and read, different clients or same client: both are granted in the same cycle.
- Same-address write+read in one cycle: the response returns the OLD word (RAM read-before-write), unless the optional feature is enabled.
- Reset values (while rst_i high and the cycle after):
  - wr_ready_o = 0, rd_ready_o = 0, ram_we_o = 0
  - all addresses/data outputs 0, rsp_valid_o = 0, wr_ptr = rd_ptr = 0, rsp_sel = 0
- Reset mid-operation: a read granted in the cycle rst_i asserts produces no response; rsp_sel clears.
- Any write presented while rst_i is high is not performed; grants are forced to 0.
- Assertions (disabled under rst_i):
  - wr_ready_o and rd_ready_o $onehot0
  - !$isunknown(wr_valid_i | rd_valid_i)
  - a client's valid must not drop before ready

Optional Feature:
- Macro: RAM_S2P1C_ARBITER_BYPASS_EN
- Defined:
  - Registers {hit, wdata} when the granted write and granted read target the same address in the same cycle.
  - Next cycle, rsp_data_o = registered wdata instead of ram_rdata_i, giving write-first semantics.
  - Adds 1 flop + WORD_WIDTH flops + one address comparator.
- Undefined: read-before-write as above; no extra logic.

Decomposition:
- Package ram_arb_pkg:
  - function client_idx_width(n) returning $clog2(n) with a minimum of 1
  - typedef for the one-hot grant vector, parameterised via the module
  - constant RSP_LATENCY = 1
- Sub-module rr_arbiter (params N; ports clk_i, rst_i, req_i[N], gnt_o[N], gnt_idx_o), instantiated twice (write and read).
- Pointer update lives inside rr_arbiter.

Test Plan:
- Single write then read: client 2 writes addr 0x10 data 0xA5, next cycle client 2 reads 0x10 -> wr_ready_o=0b0100; one cycle later rsp_valid_o=0b0100, rsp_data_o=0xA5.
- Round-robin: all 4 clients hold rd_valid for 8 cycles -> rd_ready_o sequence 0001, 0010, 0100, 1000, 0001, ... with a response each cycle, one cycle delayed.
- Concurrent ports: client 0 writes 0x20=0x11 while client 3 reads 0x30 (preloaded 0x77) in the same cycle -> both granted; rsp_valid_o=0b1000, data 0x77.
- Same-address collision: client 1 writes 0x40=0xCC while client 0 reads 0x40 (old 0x33) -> data 0x33 without the bypass macro, 0xCC with RAM_S2P1C_ARBITER_BYPASS_EN.
- Reset mid-read: grant read to client 1, assert rst_i the same cycle -> rsp_valid_o stays 0; after release, the first grant with all clients requesting goes to client 0.
- Fairness under a hog: client 0 requests writes continuously, client 3 requests once -> client 3 is granted within 4 cycles.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared constants and helpers for the two-port RAM arbiter.
package ram_arb_pkg;

  localparam int RSP_LATENCY = 1;

  // Width of a client index; never below one bit so a two-client build still has a usable index.
  function automatic int client_idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_s2p1c_arbiter_if.sv
// Client/RAM bus of the arbiter. master = surroundings (clients plus RAM read data), slave = arbiter.
interface ram_s2p1c_arbiter_if #(
  parameter int NUM_CLIENTS = 4,
  parameter int WORD_WIDTH  = 8,
  parameter int WORD_COUNT  = 256
);
  localparam int ADDR_WIDTH = $clog2(WORD_COUNT);

  logic [NUM_CLIENTS-1:0]            wr_valid_i;
  logic [NUM_CLIENTS-1:0]            wr_ready_o;
  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] wr_addr_i;
  logic [NUM_CLIENTS*WORD_WIDTH-1:0] wr_data_i;
  logic [NUM_CLIENTS-1:0]            rd_valid_i;
  logic [NUM_CLIENTS-1:0]            rd_ready_o;
  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] rd_addr_i;
  logic [NUM_CLIENTS-1:0]            rsp_valid_o;
  logic [WORD_WIDTH-1:0]             rsp_data_o;
  logic                              ram_we_o;
  logic [ADDR_WIDTH-1:0]             ram_waddr_o;
  logic [WORD_WIDTH-1:0]             ram_wdata_o;
  logic [ADDR_WIDTH-1:0]             ram_raddr_o;
  logic [WORD_WIDTH-1:0]             ram_rdata_i;

  modport master (
    output wr_valid_i, wr_addr_i, wr_data_i, rd_valid_i, rd_addr_i, ram_rdata_i,
    input  wr_ready_o, rd_ready_o, rsp_valid_o, rsp_data_o,
           ram_we_o, ram_waddr_o, ram_wdata_o, ram_raddr_o
  );

  modport slave (
    input  wr_valid_i, wr_addr_i, wr_data_i, rd_valid_i, rd_addr_i, ram_rdata_i,
    output wr_ready_o, rd_ready_o, rsp_valid_o, rsp_data_o,
           ram_we_o, ram_waddr_o, ram_wdata_o, ram_raddr_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from req_i and a rotating priority pointer.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = client_idx_width(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);

  typedef logic [N-1:0] gnt_vec_t;

  logic [IW-1:0] ptr;
  gnt_vec_t      gnt;
  logic [IW-1:0] idx;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned ofs);
    int unsigned sum;
    sum = int'(base) + ofs;
    if (sum >= unsigned'(N)) sum = sum - unsigned'(N);
    return IW'(sum);
  endfunction

  // Scan from the farthest slot back to ptr so the requester nearest ptr wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    if (!rst_i) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (req_i[wrap_add(ptr, k)]) begin
          gnt                   = '0;
          gnt[wrap_add(ptr, k)] = 1'b1;
          idx                   = wrap_add(ptr, k);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr <= '0;
    end else if (|gnt) begin
      ptr <= wrap_add(idx, 1);
    end
  end

  assign gnt_o     = gnt;
  assign gnt_idx_o = idx;

endmodule

// File: rtl/ram_s2p1c_arbiter.sv
// Shares one simple dual-port RAM (registered read) between NUM_CLIENTS clients with independent
// round-robin write and read arbitration. Define RAM_S2P1C_ARBITER_BYPASS_EN for write-first collisions.
module ram_s2p1c_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int WORD_WIDTH  = 8,
  parameter int WORD_COUNT  = 256
) (
  input logic                clk_i,
  input logic                rst_i,
  ram_s2p1c_arbiter_if.slave bus
);

  localparam int ADDR_WIDTH = $clog2(WORD_COUNT);
  localparam int IDX_WIDTH  = client_idx_width(NUM_CLIENTS);

  logic [NUM_CLIENTS-1:0] wr_gnt;
  logic [NUM_CLIENTS-1:0] rd_gnt;
  logic [NUM_CLIENTS-1:0] rsp_sel;
  logic [IDX_WIDTH-1:0]   wr_idx;
  logic [IDX_WIDTH-1:0]   rd_idx;
  logic [ADDR_WIDTH-1:0]  waddr;
  logic [ADDR_WIDTH-1:0]  raddr;
  logic [WORD_WIDTH-1:0]  wdata;

  rr_arbiter #(.N(NUM_CLIENTS)) u_wr_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (bus.wr_valid_i),
    .gnt_o     (wr_gnt),
    .gnt_idx_o (wr_idx)
  );

  rr_arbiter #(.N(NUM_CLIENTS)) u_rd_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (bus.rd_valid_i),
    .gnt_o     (rd_gnt),
    .gnt_idx_o (rd_idx)
  );

  // RAM-side buses stay at zero when their port is idle.
  always_comb begin
    waddr = '0;
    wdata = '0;
    raddr = '0;
    if (|wr_gnt) begin
      waddr = bus.wr_addr_i[int'(wr_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      wdata = bus.wr_data_i[int'(wr_idx)*WORD_WIDTH +: WORD_WIDTH];
    end
    if (|rd_gnt) begin
      raddr = bus.rd_addr_i[int'(rd_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_sel <= '0;
    end else begin
      rsp_sel <= rd_gnt;
    end
  end

  assign bus.wr_ready_o  = wr_gnt;
  assign bus.rd_ready_o  = rd_gnt;
  assign bus.ram_we_o    = |wr_gnt;
  assign bus.ram_waddr_o = waddr;
  assign bus.ram_wdata_o = wdata;
  assign bus.ram_raddr_o = raddr;
  assign bus.rsp_valid_o = rst_i ? '0 : rsp_sel;

`ifdef RAM_S2P1C_ARBITER_BYPASS_EN
  logic                  byp_hit;
  logic [WORD_WIDTH-1:0] byp_data;

  // The RAM returns the pre-write word on a same-address collision; replay the written word instead.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      byp_hit  <= 1'b0;
      byp_data <= '0;
    end else begin
      byp_hit  <= (|wr_gnt) && (|rd_gnt) && (waddr == raddr);
      byp_data <= wdata;
    end
  end

  assign bus.rsp_data_o = byp_hit ? byp_data : bus.ram_rdata_i;
`else
  assign bus.rsp_data_o = bus.ram_rdata_i;
`endif

  a_wr_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(bus.wr_ready_o));
  a_rd_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(bus.rd_ready_o));
  a_valid_known: assert property (@(posedge clk_i) disable iff (rst_i)
    !$isunknown(bus.wr_valid_i | bus.rd_valid_i));
  a_wr_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    !$past(rst_i) |-> &(bus.wr_valid_i | ~$past(bus.wr_valid_i & ~bus.wr_ready_o)));
  a_rd_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    !$past(rst_i) |-> &(bus.rd_valid_i | ~$past(bus.rd_valid_i & ~bus.rd_ready_o)));
  a_rsp_latency: assert property (@(posedge clk_i) disable iff (rst_i)
    !$past(rst_i) |-> (bus.rsp_valid_o == $past(bus.rd_ready_o, RSP_LATENCY)));

endmodule

// File: tb/tb_ram_s2p1c_arbiter.sv
// Bench for ram_s2p1c_arbiter: vector table plus reset and fairness sequences, with a response queue.
module tb_ram_s2p1c_arbiter;

  localparam int NC = 4;
  localparam int WW = 8;
  localparam int WC = 256;
  localparam int AW = 8;

`ifdef RAM_S2P1C_ARBITER_BYPASS_EN
  localparam logic [7:0] COLL_DATA = 8'hCC;
`else
  localparam logic [7:0] COLL_DATA = 8'h33;
`endif

  // Client c drives address base+c and data base+c on each port.
  typedef struct {
    logic [3:0] wv;
    logic [7:0] wa;
    logic [7:0] wd;
    logic [3:0] rv;
    logic [7:0] ra;
    logic [3:0] ew;
    logic [3:0] er;
    logic [7:0] ed;
  } vec_t;

  typedef struct {
    logic [3:0] vld;
    logic [7:0] dat;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];
  rsp_t exp_q[$];
  logic [7:0] mem [WC];

  always #5 clk = ~clk;

  ram_s2p1c_arbiter_if #(.NUM_CLIENTS(NC), .WORD_WIDTH(WW), .WORD_COUNT(WC)) bus();

  ram_s2p1c_arbiter #(.NUM_CLIENTS(NC), .WORD_WIDTH(WW), .WORD_COUNT(WC)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // External RAM: synchronous write, registered read, read-before-write.
  initial for (int i = 0; i < WC; i++) mem[i] = 8'(i);
  always @(posedge clk) begin
    if (bus.ram_we_o) mem[bus.ram_waddr_o] <= bus.ram_wdata_o;
    bus.ram_rdata_i <= mem[bus.ram_raddr_o];
  end

  function automatic vec_t mkv(logic [3:0] wv, logic [7:0] wa, logic [7:0] wd, logic [3:0] rv,
                               logic [7:0] ra, logic [3:0] ew, logic [3:0] er, logic [7:0] ed);
    vec_t t;
    t.wv = wv; t.wa = wa; t.wd = wd; t.rv = rv;
    t.ra = ra; t.ew = ew; t.er = er; t.ed = ed;
    return t;
  endfunction

  function automatic int oh_idx(logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input vec_t vec, input logic r, input bit chk_gnt);
    rsp_t e;
    int   wi;
    int   ri;
    @(negedge clk);
    rst             = r;
    bus.wr_valid_i  = vec.wv;
    bus.rd_valid_i  = vec.rv;
    for (int c = 0; c < NC; c++) begin
      bus.wr_addr_i[c*AW +: AW] = vec.wa + 8'(c);
      bus.wr_data_i[c*WW +: WW] = vec.wd + 8'(c);
      bus.rd_addr_i[c*AW +: AW] = vec.ra + 8'(c);
    end
    #1;
    e.vld = 4'h0;
    e.dat = 8'h0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    if (r) e.vld = 4'h0;
    chk("rsp_valid", 32'(bus.rsp_valid_o), 32'(e.vld));
    if (e.vld != 4'h0) chk("rsp_data", 32'(bus.rsp_data_o), 32'(e.dat));
    if (chk_gnt) begin
      wi = oh_idx(vec.ew);
      ri = oh_idx(vec.er);
      chk("wr_ready", 32'(bus.wr_ready_o), 32'(vec.ew));
      chk("rd_ready", 32'(bus.rd_ready_o), 32'(vec.er));
      chk("ram_we", 32'(bus.ram_we_o), 32'(|vec.ew));
      chk("ram_waddr", 32'(bus.ram_waddr_o), 32'((vec.ew != 4'h0) ? vec.wa + 8'(wi) : 8'h0));
      chk("ram_wdata", 32'(bus.ram_wdata_o), 32'((vec.ew != 4'h0) ? vec.wd + 8'(wi) : 8'h0));
      chk("ram_raddr", 32'(bus.ram_raddr_o), 32'((vec.er != 4'h0) ? vec.ra + 8'(ri) : 8'h0));
    end
    e.vld = r ? 4'h0 : vec.er;
    e.dat = vec.ed;
    exp_q.push_back(e);
  endtask

  initial begin
    vec_t idle;
    bit   granted;
    int   n;

    rst            = 1'b1;
    bus.wr_valid_i = '0;
    bus.rd_valid_i = '0;
    bus.wr_addr_i  = '0;
    bus.wr_data_i  = '0;
    bus.rd_addr_i  = '0;
    idle = mkv(4'h0, 8'h00, 8'h00, 4'h0, 8'h00, 4'h0, 4'h0, 8'h00);

    //                wv       wa     wd     rv       ra     ew       er       ed
    tbl.push_back(idle);
    for (int i = 0; i < 8; i++)
      tbl.push_back(mkv(4'b0000, 8'h00, 8'h00, 4'b1111, 8'h80, 4'b0000, 4'(1 << (i % 4)), 8'(8'h80 + i % 4)));
    tbl.push_back(mkv(4'b0000, 8'h00, 8'h00, 4'b0111, 8'h80, 4'b0000, 4'b0001, 8'h80));
    tbl.push_back(mkv(4'b0000, 8'h00, 8'h00, 4'b0110, 8'h80, 4'b0000, 4'b0010, 8'h81));
    tbl.push_back(mkv(4'b0000, 8'h00, 8'h00, 4'b0100, 8'h80, 4'b0000, 4'b0100, 8'h82));
    tbl.push_back(mkv(4'b0100, 8'h0E, 8'hA3, 4'b0000, 8'h00, 4'b0100, 4'b0000, 8'h00));
    tbl.push_back(mkv(4'b0000, 8'h00, 8'h00, 4'b0100, 8'h0E, 4'b0000, 4'b0100, 8'hA5));
    tbl.push_back(mkv(4'b1000, 8'h2D, 8'h74, 4'b0000, 8'h00, 4'b1000, 4'b0000, 8'h00));
    tbl.push_back(mkv(4'b0001, 8'h40, 8'h33, 4'b0000, 8'h00, 4'b0001, 4'b0000, 8'h00));
    tbl.push_back(mkv(4'b0001, 8'h20, 8'h11, 4'b1000, 8'h2D, 4'b0001, 4'b1000, 8'h77));
    tbl.push_back(mkv(4'b0010, 8'h3F, 8'hCB, 4'b0001, 8'h40, 4'b0010, 4'b0001, COLL_DATA));
    tbl.push_back(mkv(4'b0000, 8'h00, 8'h00, 4'b0001, 8'h40, 4'b0000, 4'b0001, 8'hCC));
    tbl.push_back(mkv(4'b0000, 8'h00, 8'h00, 4'b0010, 8'h1F, 4'b0000, 4'b0010, 8'h11));
    tbl.push_back(mkv(4'b0100, 8'h4E, 8'h5C, 4'b0100, 8'h5E, 4'b0100, 4'b0100, 8'h60));
    tbl.push_back(mkv(4'b0000, 8'h00, 8'h00, 4'b0001, 8'h50, 4'b0000, 4'b0001, 8'h5E));
    tbl.push_back(idle);

    // Reset: grants forced low even with every client requesting.
    step(idle, 1'b1, 1'b1);
    step(mkv(4'b1111, 8'h00, 8'h00, 4'b1111, 8'h00, 4'h0, 4'h0, 8'h00), 1'b1, 1'b1);

    foreach (tbl[i]) step(tbl[i], 1'b0, 1'b1);

    // Write hog on client 0; client 3 asks once and must be served within NC cycles.
    step(mkv(4'b0001, 8'h90, 8'h00, 4'h0, 8'h00, 4'b0001, 4'h0, 8'h00), 1'b0, 1'b1);
    granted = 1'b0;
    n       = 0;
    while (!granted && n < NC) begin
      step(mkv(4'b1001, 8'h90, 8'h00, 4'h0, 8'h00, 4'h0, 4'h0, 8'h00), 1'b0, 1'b0);
      n++;
      if (bus.wr_ready_o[3]) granted = 1'b1;
    end
    chk("hog_fairness", 32'(granted), 32'(1));
    step(mkv(4'b0001, 8'h90, 8'h00, 4'h0, 8'h00, 4'b0001, 4'h0, 8'h00), 1'b0, 1'b0);

    // Reset arrives with a read (client 1) and a write pending: nothing granted, no response,
    // then pointers restart at client 0.
    step(mkv(4'b0100, 8'hB0, 8'h10, 4'b0010, 8'hA0, 4'h0, 4'h0, 8'h00), 1'b1, 1'b1);
    step(idle, 1'b0, 1'b1);
    step(mkv(4'b1111, 8'hB0, 8'h10, 4'b1111, 8'hA0, 4'b0001, 4'b0001, 8'hA0), 1'b0, 1'b1);
    step(mkv(4'b1110, 8'hB0, 8'h10, 4'b1110, 8'hA0, 4'b0010, 4'b0010, 8'hA1), 1'b0, 1'b1);
    step(mkv(4'b1100, 8'hB0, 8'h10, 4'b1100, 8'hA0, 4'b0100, 4'b0100, 8'hA2), 1'b0, 1'b1);
    step(mkv(4'b1000, 8'hB0, 8'h10, 4'b1000, 8'hA0, 4'b1000, 4'b1000, 8'hA3), 1'b0, 1'b1);
    step(idle, 1'b0, 1'b1);
    step(idle, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
